// File: rtl/fetch_stage.sv
// Instruction-fetch stage with the F/D pipeline register.
// Owns the PC, runs a req/ack fetch handshake, buffers one word while
// decode is stalled and applies branch/jump redirects (with a kill of an
// in-flight fetch when the redirect arrives mid-request).
//
// Handshake: IMEM_REQ rises with IMEM_ADDR and both stay constant until the
// cycle IMEM_ACK is seen high with IMEM_REQ=1; IMEM_DATA is consumed in that
// same cycle. IMEM_ACK is ignored while IMEM_REQ=0.
module fetch_stage #(
   parameter logic [31:0] RESET_VEC = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        STALL,
   input  logic        FLUSH,
   input  logic [31:0] D_TARGET,
   input  logic        BR_TAKEN,
   input  logic [31:0] BR_TARGET,
   output logic        IMEM_REQ,
   output logic [31:0] IMEM_ADDR,
   input  logic        IMEM_ACK,
   input  logic [31:0] IMEM_DATA,
   output logic [31:0] D_IR,
   output logic [31:0] D_PC,
   output logic [31:0] D_PC4,
   output logic        D_VALID,
   output logic        FETCH_BUSY
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t      state_q;
   logic [31:0] pc_q;
   logic [31:0] pend_q;
   logic [31:0] buf_q;
   logic        kill_q;
   logic [31:0] d_ir_q;
   logic [31:0] d_pc_q;
   logic        d_valid_q;

   logic        redirect;
   logic [31:0] redir_tgt;
   logic        outstanding;
   logic [31:0] pc_plus4;

   // Older instruction (branch in execute) beats the jump in decode.
   assign redirect    = BR_TAKEN | FLUSH;
   assign redir_tgt   = (BR_TAKEN ? BR_TARGET : D_TARGET) & 32'hFFFF_FFFC;
   // A request is in flight and its data has not come back this cycle.
   assign outstanding = (state_q == S_REQ) && !IMEM_ACK;
   assign pc_plus4    = pc_q + 32'd4;

   // Fetch FSM, PC, kill/pending-target, one-word buffer and F/D register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= S_IDLE;
         pc_q      <= RESET_VEC & 32'hFFFF_FFFC;
         pend_q    <= 32'd0;
         buf_q     <= 32'd0;
         kill_q    <= 1'b0;
         d_ir_q    <= NOP_INSTR;
         d_pc_q    <= 32'd0;
         d_valid_q <= 1'b0;
      end else if (redirect) begin
         // Bubble F/D, drop any buffered word and go fetch the target.
         state_q   <= S_REQ;
         d_ir_q    <= NOP_INSTR;
         d_valid_q <= 1'b0;
         if (outstanding) begin
            // Keep the old address on the bus until memory answers it.
            kill_q <= 1'b1;
            pend_q <= redir_tgt;
         end else begin
            kill_q <= 1'b0;
            pc_q   <= redir_tgt;
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               state_q <= S_REQ;
            end
            S_REQ: begin
               if (IMEM_ACK) begin
                  if (kill_q) begin
                     // Word belongs to the wrong path: drop it.
                     kill_q <= 1'b0;
                     pc_q   <= pend_q;
                  end else if (STALL) begin
                     buf_q   <= IMEM_DATA;
                     state_q <= S_HOLD;
                  end else begin
                     d_ir_q    <= IMEM_DATA;
                     d_pc_q    <= pc_q;
                     d_valid_q <= 1'b1;
                     pc_q      <= pc_plus4;
                  end
               end else if (!STALL) begin
                  d_ir_q    <= NOP_INSTR;
                  d_valid_q <= 1'b0;
               end
            end
            S_HOLD: begin
               if (!STALL) begin
                  d_ir_q    <= buf_q;
                  d_pc_q    <= pc_q;
                  d_valid_q <= 1'b1;
                  pc_q      <= pc_plus4;
                  state_q   <= S_REQ;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign IMEM_REQ   = (state_q == S_REQ);
   assign IMEM_ADDR  = pc_q;
   assign D_IR       = d_ir_q;
   assign D_PC       = d_pc_q;
   assign D_PC4      = d_pc_q + 32'd4;
   assign D_VALID    = d_valid_q;
   assign FETCH_BUSY = (state_q == S_IDLE) || ((state_q == S_REQ) && !IMEM_ACK);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by randomized
// stall/redirect/ack/reset traffic, all checked every cycle against a
// behavioural model of the fetch rules.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        CLK = 1'b0;
   logic        RST, STALL, FLUSH, BR_TAKEN, IMEM_ACK;
   logic [31:0] D_TARGET, BR_TARGET, IMEM_DATA;
   logic        IMEM_REQ, D_VALID, FETCH_BUSY;
   logic [31:0] IMEM_ADDR, D_IR, D_PC, D_PC4;

   int n_checks = 0;
   int n_errors = 0;

   // clock / reset block
   always #5 CLK = ~CLK;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h5A00_0001;
   endfunction

   // instruction memory: data always reflects the address on the bus
   assign IMEM_DATA = mem_word(IMEM_ADDR);

   fetch_stage dut (
      .CLK        (CLK),
      .RST        (RST),
      .STALL      (STALL),
      .FLUSH      (FLUSH),
      .D_TARGET   (D_TARGET),
      .BR_TAKEN   (BR_TAKEN),
      .BR_TARGET  (BR_TARGET),
      .IMEM_REQ   (IMEM_REQ),
      .IMEM_ADDR  (IMEM_ADDR),
      .IMEM_ACK   (IMEM_ACK),
      .IMEM_DATA  (IMEM_DATA),
      .D_IR       (D_IR),
      .D_PC       (D_PC),
      .D_PC4      (D_PC4),
      .D_VALID    (D_VALID),
      .FETCH_BUSY (FETCH_BUSY)
   );

   // behavioural model of the fetch rules
   logic        m_fresh;   // first cycle after reset, nothing requested
   logic        m_held;    // a fetched word waits for decode to accept it
   logic        m_dead;    // the outstanding fetch must be discarded
   logic [31:0] m_pc;      // address being / to be fetched
   logic [31:0] m_pend;    // where to go once the dead fetch returns
   logic [31:0] m_buf;
   logic [31:0] m_ir, m_dpc;
   logic        m_valid;

   // previous-cycle bus view for the stability check
   logic        p_req, p_ack, p_rst;
   logic [31:0] p_addr;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_fresh = 1'b1; m_held = 1'b0; m_dead = 1'b0;
      m_pc = 32'd0; m_pend = 32'd0; m_buf = 32'd0;
      m_ir = NOP; m_dpc = 32'd0; m_valid = 1'b0;
      p_req = 1'b0; p_ack = 1'b0; p_rst = 1'b1; p_addr = 32'd0;
   endtask

   task automatic deliver(input logic [31:0] w, input logic [31:0] pc);
      m_ir = w; m_dpc = pc; m_valid = 1'b1;
   endtask

   // compare DUT outputs with the model at mid-cycle
   task automatic check_now();
      logic exp_req;
      exp_req = !m_fresh && !m_held;
      chk("imem_req", IMEM_REQ, exp_req);
      if (exp_req) chk("imem_addr", IMEM_ADDR, m_pc);
      chk("fetch_busy", FETCH_BUSY, m_fresh || (!m_held && !IMEM_ACK));
      chk("d_valid", D_VALID, m_valid);
      chk("d_ir", D_IR, m_ir);
      if (m_valid) begin
         chk("d_pc", D_PC, m_dpc);
         chk("d_pc4", D_PC4, m_dpc + 32'd4);
      end
      if (p_req && !p_ack && !p_rst) begin
         chk("hs_req_stable", IMEM_REQ, 1'b1);
         chk("hs_addr_stable", IMEM_ADDR, p_addr);
      end
      p_req = IMEM_REQ; p_ack = IMEM_ACK; p_rst = RST; p_addr = IMEM_ADDR;
   endtask

   // advance the model across the coming clock edge
   task automatic model_edge();
      logic [31:0] tgt;
      if (RST) begin
         model_reset();
      end else if (BR_TAKEN || FLUSH) begin
         tgt = (BR_TAKEN ? BR_TARGET : D_TARGET) & 32'hFFFF_FFFC;
         m_ir = NOP; m_valid = 1'b0;
         if (!m_fresh && !m_held && !IMEM_ACK) begin
            m_dead = 1'b1; m_pend = tgt;
         end else begin
            m_dead = 1'b0; m_pc = tgt;
         end
         m_fresh = 1'b0; m_held = 1'b0;
      end else if (m_fresh) begin
         m_fresh = 1'b0;
      end else if (m_held) begin
         if (!STALL) begin
            deliver(m_buf, m_pc); m_pc = m_pc + 32'd4; m_held = 1'b0;
         end
      end else if (IMEM_ACK) begin
         if (m_dead) begin
            m_dead = 1'b0; m_pc = m_pend;
         end else if (STALL) begin
            m_held = 1'b1; m_buf = mem_word(m_pc);
         end else begin
            deliver(mem_word(m_pc), m_pc); m_pc = m_pc + 32'd4;
         end
      end else if (!STALL) begin
         m_ir = NOP; m_valid = 1'b0;
      end
   endtask

   // driver: apply one cycle of inputs, check mid-cycle, end at posedge+1
   task automatic step(input logic rst, input logic ack, input logic stall,
                       input logic flush, input logic br,
                       input logic [31:0] dt, input logic [31:0] bt);
      RST = rst; IMEM_ACK = ack; STALL = stall; FLUSH = flush;
      BR_TAKEN = br; D_TARGET = dt; BR_TARGET = bt;
      @(negedge CLK);
      check_now();
      model_edge();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RST = 1'b1; IMEM_ACK = 1'b1; STALL = 1'b0; FLUSH = 1'b0;
      BR_TAKEN = 1'b0; D_TARGET = 32'd0; BR_TARGET = 32'd0;
      @(posedge CLK);
      #1;
      model_reset();

      // 1: reset, idle cycle, zero-bubble streaming
      step(1, 1, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0);
      chk("t1_req_after_idle", IMEM_REQ, 1'b1);
      step(0, 1, 0, 0, 0, 0, 0);
      chk("t1_pc0", D_PC, 32'h0);
      step(0, 1, 0, 0, 0, 0, 0);
      chk("t1_pc4", D_PC, 32'h4);
      step(0, 1, 0, 0, 0, 0, 0);
      chk("t1_pc8", D_PC, 32'h8);
      chk("t1_pc8_plus4", D_PC4, 32'hC);
      chk("t1_ir8", D_IR, mem_word(32'h8));

      // 2: stall three cycles with word 12 buffered
      for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 0, 0);
      chk("t2_pc_held", D_PC, 32'h8);
      chk("t2_hold_no_req", IMEM_REQ, 1'b0);
      step(0, 1, 0, 0, 0, 0, 0);
      chk("t2_pc12", D_PC, 32'hC);
      chk("t2_ir12", D_IR, mem_word(32'hC));
      step(0, 1, 0, 0, 0, 0, 0);
      chk("t2_pc16", D_PC, 32'h10);

      // 3: delayed ack at 0x10, flush to 0x40 in the first wait cycle
      step(0, 1, 0, 0, 1, 0, 32'h10);
      step(0, 0, 0, 1, 0, 32'h40, 0);
      chk("t3_addr_wait1", IMEM_ADDR, 32'h10);
      chk("t3_req_wait1", IMEM_REQ, 1'b1);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("t3_addr_wait2", IMEM_ADDR, 32'h10);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("t3_addr_wait3", IMEM_ADDR, 32'h10);
      chk("t3_bubble", D_VALID, 1'b0);
      step(0, 1, 0, 0, 0, 0, 0);
      chk("t3_addr_target", IMEM_ADDR, 32'h40);
      chk("t3_discarded", D_VALID, 1'b0);
      step(0, 1, 0, 0, 0, 0, 0);
      chk("t3_valid40", D_VALID, 1'b1);
      chk("t3_pc40", D_PC, 32'h40);

      // 4: branch and flush together
      step(0, 1, 0, 1, 1, 32'h200, 32'h80);
      chk("t4_addr", IMEM_ADDR, 32'h80);
      chk("t4_valid", D_VALID, 1'b0);
      chk("t4_ir_nop", D_IR, NOP);

      // 5: PC wrap and target alignment
      step(0, 1, 0, 0, 1, 0, 32'hFFFF_FFFC);
      chk("t5_addr_top", IMEM_ADDR, 32'hFFFF_FFFC);
      step(0, 1, 0, 0, 0, 0, 0);
      chk("t5_wrap", IMEM_ADDR, 32'h0);
      chk("t5_pc_top", D_PC, 32'hFFFF_FFFC);
      chk("t5_pc4_wrap", D_PC4, 32'h0);
      step(0, 1, 0, 1, 0, 32'h103, 0);
      chk("t5_align", IMEM_ADDR, 32'h100);

      // 6: reset mid-request with memory acking during reset
      step(0, 0, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0);
      chk("t6_req", IMEM_REQ, 1'b0);
      chk("t6_valid", D_VALID, 1'b0);
      chk("t6_ir", D_IR, NOP);
      chk("t6_pc", D_PC, 32'h0);
      chk("t6_pc4", D_PC4, 32'h4);
      step(0, 1, 0, 0, 0, 0, 0);
      chk("t6_first_req", IMEM_REQ, 1'b1);
      chk("t6_first_addr", IMEM_ADDR, 32'h0);

      // random streaming with ack tied high and light stalls
      for (int i = 0; i < 400; i++)
         step(0, 1, ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0),
              ($urandom_range(0, 19) == 0), $urandom(), $urandom());

      // random everything: slow memory, stalls, redirects, resets
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] dt, bt;
         dt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom();
         bt = $urandom();
         step(($urandom_range(0, 149) == 0), ($urandom_range(0, 9) < 6),
              ($urandom_range(0, 4) == 0), ($urandom_range(0, 11) == 0),
              ($urandom_range(0, 11) == 0), dt, bt);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
